// File: rtl/divider_params.sv
// Shared types and sizing for the iterative MIPS divider.
package divider_params;

    localparam int DATA_WIDTH        = 32;
    localparam int DIVIDE_ITERATIONS = DATA_WIDTH;
    localparam int COUNT_WIDTH       = $clog2(DIVIDE_ITERATIONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } DividerState;

    typedef struct packed {
        logic                  is_signed;
        logic [DATA_WIDTH-1:0] dividend;
        logic [DATA_WIDTH-1:0] divisor;
    } DivideRequest;

endpackage

// File: rtl/divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module divider_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] remain,
    input  logic                  next_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] remain_next,
    output logic                  quotient_bit
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] difference;

    always_comb begin
        shifted    = {remain, next_bit};
        difference = shifted - {1'b0, divisor};
        // Borrow out of the extra top bit means the divisor did not fit.
        if (difference[DATA_WIDTH]) begin
            remain_next  = shifted[DATA_WIDTH-1:0];
            quotient_bit = 1'b0;
        end else begin
            remain_next  = difference[DATA_WIDTH-1:0];
            quotient_bit = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_divider.sv
// Iterative radix-2 restoring divider serving DIV/DIVU; holds the result until acknowledged.
module cpu_divider
    import divider_params::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  divide_start_valid,
    output logic                  divide_start_ready,
    input  logic                  divide_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  divide_result_valid,
    input  logic                  divide_result_ready,
    output logic [DATA_WIDTH-1:0] divide_result,
    output logic [DATA_WIDTH-1:0] divide_remain
);

    localparam int COUNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    DividerState state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0] remain_q, remain_d;
    logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0] dividend_q, dividend_d;
    logic                  quo_neg_q, quo_neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic                  div_zero_q, div_zero_d;

    logic                  accept;
    logic                  dividend_neg;
    logic                  divisor_neg;
    logic [DATA_WIDTH-1:0] step_remain;
    logic                  step_bit;

    // The quotient register starts out holding |dividend| and its MSB feeds each step.
    divider_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .remain       (remain_q),
        .next_bit     (quotient_q[DATA_WIDTH-1]),
        .divisor      (divisor_q),
        .remain_next  (step_remain),
        .quotient_bit (step_bit)
    );

    always_comb begin
        divide_start_ready = ((state_q == IDLE) || ((state_q == DONE) && divide_result_ready))
                             && !flush;
        accept       = divide_start_valid && divide_start_ready;
        dividend_neg = divide_signed && dividend[DATA_WIDTH-1];
        divisor_neg  = divide_signed && divisor[DATA_WIDTH-1];

        state_d    = state_q;
        count_d    = count_q;
        remain_d   = remain_q;
        quotient_d = quotient_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            IDLE: ;
            BUSY: begin
                remain_d   = step_remain;
                quotient_d = {quotient_q[DATA_WIDTH-2:0], step_bit};
                count_d    = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (divide_result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d    = BUSY;
            count_d    = COUNT_W'(DATA_WIDTH - 1);
            remain_d   = '0;
            quotient_d = dividend_neg ? -dividend : dividend;
            divisor_d  = divisor_neg ? -divisor : divisor;
            dividend_d = dividend;
            quo_neg_d  = dividend_neg ^ divisor_neg;
            rem_neg_d  = dividend_neg;
            div_zero_d = (divisor == '0);
        end

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            remain_q   <= '0;
            quotient_q <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            remain_q   <= remain_d;
            quotient_q <= quotient_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        divide_result_valid = (state_q == DONE);
        divide_result       = '0;
        divide_remain       = '0;
        if (divide_result_valid) begin
            if (div_zero_q) begin
                divide_result = '1;
                divide_remain = dividend_q;
            end else begin
                divide_result = quo_neg_q ? -quotient_q : quotient_q;
                divide_remain = rem_neg_q ? -remain_q : remain_q;
            end
        end
    end

endmodule

// File: tb/tb_cpu_divider.sv
// Directed self-checking bench for cpu_divider (DIV/DIVU, back-pressure, flush, reset).
module tb_cpu_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        divide_start_valid;
    logic        divide_start_ready;
    logic        divide_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        divide_result_valid;
    logic        divide_result_ready;
    logic [31:0] divide_result;
    logic [31:0] divide_remain;

    int n_checks = 0;
    int n_fails  = 0;

    cpu_divider #(
        .DATA_WIDTH (32)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .flush               (flush),
        .divide_start_valid  (divide_start_valid),
        .divide_start_ready  (divide_start_ready),
        .divide_signed       (divide_signed),
        .dividend            (dividend),
        .divisor             (divisor),
        .divide_result_valid (divide_result_valid),
        .divide_result_ready (divide_result_ready),
        .divide_result       (divide_result),
        .divide_remain       (divide_remain)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request at the current negedge and let it be accepted on the next edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        divide_start_valid = 1'b1;
        divide_signed      = sgn;
        dividend           = a;
        divisor            = b;
        #1;
        check_value({tag, "_start_ready"}, {31'b0, divide_start_ready}, 32'd1);
        @(posedge clock);
        #1;
        divide_start_valid = 1'b0;
        // Operands are only sampled on the accept edge.
        dividend           = 32'hDEAD_BEEF;
        divisor            = 32'h0000_0003;
        divide_signed      = ~sgn;
    endtask

    // Count edges after accept until result_valid is seen at a negedge (bounded).
    task automatic wait_result(output int cycles);
        cycles = 0;
        do begin
            @(posedge clock);
            cycles++;
            @(negedge clock);
        end while (!divide_result_valid && cycles < 100);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input string tag);
        int cycles;
        issue(sgn, a, b, tag);
        wait_result(cycles);
        check_value({tag, "_latency"}, cycles, 32'd32);
        check_value({tag, "_result"}, divide_result, exp_q);
        check_value({tag, "_remain"}, divide_remain, exp_r);
        check_value({tag, "_ready_done"}, {31'b0, divide_start_ready}, 32'd1);
        @(negedge clock);
        check_value({tag, "_retired"}, {31'b0, divide_result_valid}, 32'd0);
    endtask

    task automatic watch_no_result(input int n, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            seen |= divide_result_valid;
        end
        check_value({tag, "_no_result"}, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        int cycles;
        reset               = 1'b1;
        flush               = 1'b0;
        divide_start_valid  = 1'b0;
        divide_signed       = 1'b0;
        dividend            = '0;
        divisor             = '0;
        divide_result_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_value("rst_valid", {31'b0, divide_result_valid}, 32'd0);
        check_value("rst_ready", {31'b0, divide_start_ready}, 32'd1);
        check_value("rst_result", divide_result, 32'd0);
        check_value("rst_remain", divide_remain, 32'd0);
        @(negedge clock);

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div_7_m2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_ovf");
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "divu_ovf");
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "divu_5_0");
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "div_m5_0");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "divu_max_1");

        // Back-pressure: result must hold steady while ready is low.
        divide_result_ready = 1'b0;
        issue(1'b0, 32'd100, 32'd7, "bp");
        wait_result(cycles);
        check_value("bp_latency", cycles, 32'd32);
        for (int i = 0; i < 10; i++) begin
            check_value("bp_valid", {31'b0, divide_result_valid}, 32'd1);
            check_value("bp_result", divide_result, 32'd14);
            check_value("bp_remain", divide_remain, 32'd2);
            check_value("bp_start_ready", {31'b0, divide_start_ready}, 32'd0);
            @(negedge clock);
        end
        divide_result_ready = 1'b1;
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "bp_next");

        // Flush in the 10th BUSY cycle, with a request presented on the flush edge.
        issue(1'b0, 32'd1000, 32'd3, "fl");
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush              = 1'b1;
        divide_start_valid = 1'b1;
        dividend           = 32'd50;
        divisor            = 32'd5;
        #1;
        check_value("fl_start_ready", {31'b0, divide_start_ready}, 32'd0);
        @(negedge clock);
        flush              = 1'b0;
        divide_start_valid = 1'b0;
        #1;
        check_value("fl_idle_ready", {31'b0, divide_start_ready}, 32'd1);
        check_value("fl_valid", {31'b0, divide_result_valid}, 32'd0);
        watch_no_result(40, "fl");
        run_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, "fl_next");

        // Synchronous reset in the middle of BUSY.
        issue(1'b1, 32'hFFFF_FF00, 32'd7, "rb");
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_value("rb_valid", {31'b0, divide_result_valid}, 32'd0);
        check_value("rb_ready", {31'b0, divide_start_ready}, 32'd1);
        check_value("rb_result", divide_result, 32'd0);
        check_value("rb_remain", divide_remain, 32'd0);
        reset = 1'b0;
        watch_no_result(40, "rb");
        run_div(1'b0, 32'd1234, 32'd10, 32'd123, 32'd4, "rb_next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cpu_divider.md
# cpu_divider

Iterative radix-2 restoring divider for the MIPS core, serving DIV and DIVU. The EX stage issues one division per request. The divider produces the quotient and remainder that the memory stage waits on before it writes LO and HI. The block is the result-producing end of the `divide_valid` / `divide_result_valid` exchange. It holds each result until the consumer acknowledges it.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `clock`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `flush`  in  1: cancels any in-flight or completed division.
- `divide_start_valid`  in  1: request present.
- `divide_start_ready`  out  1: request accepted on this edge when high together with valid.
- `divide_signed`  in  1: 1 selects DIV (two's complement), 0 selects DIVU.
- `dividend`  in  DATA_WIDTH: dividend.
- `divisor`  in  DATA_WIDTH: divisor.
- `divide_result_valid`  out  1: quotient and remainder are valid.
- `divide_result_ready`  in  1: consumer takes the result on this edge.
- `divide_result`  out  DATA_WIDTH: quotient (goes to LO).
- `divide_remain`  out  DATA_WIDTH: remainder (goes to HI).

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: iterating.
  - DONE: result held for the consumer.
- IDLE → BUSY on `divide_start_valid & divide_start_ready`. On that edge the block captures:
  - |dividend| and |divisor|. Absolute values apply only when `divide_signed`; otherwise the raw operands.
  - quotient sign = sign(dividend) XOR sign(divisor), signed only.
  - remainder sign = sign(dividend), signed only.
  - a divide-by-zero flag.
  - iteration counter = DATA_WIDTH − 1.
- BUSY, each edge:
  - Shift the partial remainder left by 1 and bring in the next dividend MSB.
  - Trial-subtract the divisor at width DATA_WIDTH+1.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise keep the shifted remainder and shift in 0.
  - Decrement the counter.
  - The edge that processes counter == 0 moves to DONE.
- DONE, combinational outputs:
  - `divide_result` = quotient negated if the quotient-sign flag is set.
  - `divide_remain` = remainder negated if the remainder-sign flag is set.
  - Divide by zero overrides both: quotient = all ones, remainder = original dividend. The same latency applies.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is the natural unsigned-magnitude result; no special case is needed.
- DONE → IDLE on `divide_result_ready`.
- `divide_start_ready` = IDLE | (DONE & `divide_result_ready`). A back-to-back request is accepted on the same edge the result is retired, and the block goes directly to BUSY.
- `flush` has priority over every transition except reset:
  - The next state is IDLE.
  - No request is accepted on a flush edge, even if start handshaking.
  - A DONE result is discarded.
- Outputs while `divide_result_valid` is low: `divide_result` = `divide_remain` = 0.

## Timing
- Reset values:
  - state IDLE.
  - `divide_start_ready` = 1.
  - `divide_result_valid` = 0.
  - `divide_result` = `divide_remain` = 0.
  - All datapath registers are zero.
- Reset mid-operation abandons the division. No result appears.
- Latency: request accepted at edge T. BUSY spans edges T+1 … T+DATA_WIDTH. `divide_result_valid` is high in the cycle after edge T+DATA_WIDTH, i.e. DATA_WIDTH cycles after acceptance (32 by default).
- `divide_result_valid` stays high, with stable outputs, until the edge that samples `divide_result_ready` = 1, or until flush/reset.
- Operand inputs are sampled only on the accept edge. Changes afterwards have no effect.
- `divide_start_ready` depends combinationally on `divide_result_ready`. There is no combinational path from `divide_start_valid` to any output.
- Throughput: one division per DATA_WIDTH+1 cycles with ready held high. The DONE cycle overlaps with the accept of the next request.

## Structure
- Package `divider_params`:
  - `DividerState` enum (IDLE, BUSY, DONE).
  - `DIVIDE_ITERATIONS` = DATA_WIDTH.
  - a counter-width localparam.
  - a `DivideRequest` packed struct (signed, dividend, divisor).
- One sub-module, `divider_step`: combinational shift-and-trial-subtract producing the next partial remainder and the quotient bit. It is instantiated once; the iteration is sequential.
- Sign fixup and the divide-by-zero override live in `cpu_divider`.

## Test plan
- DIVU 100 / 7, ready held high → `divide_result_valid` exactly 32 cycles after accept, result 14, remain 2; `divide_start_ready` high in the DONE cycle.
- DIV −7 / 2 → result 0xFFFFFFFD, remain 0xFFFFFFFF. DIV 7 / −2 → result 0xFFFFFFFD, remain 1.
- Overflow operands:
  - DIV 0x80000000 / 0xFFFFFFFF → result 0x80000000, remain 0.
  - DIVU with the same operands → result 0, remain 0x80000000.
- Divide by zero:
  - DIVU 5 / 0 → result 0xFFFFFFFF, remain 5 after 32 cycles.
  - DIV −5 / 0 → result 0xFFFFFFFF, remain 0xFFFFFFFB.
- Back-pressure: hold `divide_result_ready` low for 10 cycles → valid and outputs are stable throughout, and `divide_start_ready` stays low. Then raise ready together with a new request 9 / 3 → the second result 3 / 0 appears 32 cycles after that edge.
- Cancellation:
  - Flush at the 10th BUSY cycle → no result, IDLE next cycle, and a new 20 / 6 gives 3 / 2.
  - Reset mid-BUSY → all outputs at their reset values the following cycle.
